viterbi_dec_param: RTL

Parametrised hard-decision Viterbi decoder for rate-1/R, constraint-length K convolutional codes. It accepts one complete frame per start pulse and runs one trellis stage per cycle, with all 2^(K-1) add-compare-select (ACS) units in parallel. It then traces back through an on-chip survivor memory and returns the decoded message plus its final path metric. Generator polynomials and trellis termination mode are run-time inputs, so no precomputed state table is needed. It replaces the fixed r=2/K=3 decoder in the information-processing datapath.

---
 rtl/viterbi_dec_param.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_dec_param.sv
// viterbi_dec_param
// Hard-decision Viterbi decoder for rate-1/R, constraint-length K
// convolutional codes. A frame is accepted on start, decoded with one
// trellis stage per cycle (all NS add-compare-select units in parallel),
// then traced back through the survivor memory one bit per cycle.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    frame request, sampled only while idle
//   codein   received frame, first-transmitted bit in the MSB
//   gens     generator j at gens[j*K +: K], tap K-1 is the current input
//   term     1: trace back from state 0, 0: from the minimum-metric state
//   busy     frame in progress
//   done     one-cycle pulse when codeout/metric are updated
//   codeout  decoded message, first decoded bit in the MSB
//   metric   path metric of the traceback start state
module viterbi_dec_param #(
    parameter int R      = 2,
    parameter int K      = 3,
    parameter int LENOUT = 5,
    parameter int MW     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [R*LENOUT-1:0]   codein,
    input  logic [R*K-1:0]        gens,
    input  logic                  term,
    output logic                  busy,
    output logic                  done,
    output logic [LENOUT-1:0]     codeout,
    output logic [MW-1:0]         metric
);
    localparam int LENIN = R * LENOUT;
    localparam int NS    = 1 << (K - 1);
    localparam int SW    = K - 1;
    localparam int TW    = $clog2(LENOUT);
    localparam logic [TW-1:0] LAST   = TW'(LENOUT - 1);
    localparam logic [MW-1:0] PM_MAX = '1;

    typedef enum logic [2:0] {IDLE, ACS, SELECT, FETCH, TRACE} state_t;

    state_t              state_reg, state_next;
    logic [TW-1:0]       cnt_reg;
    logic [LENIN-1:0]    cin_reg;
    logic [R*K-1:0]      gens_reg;
    logic                term_reg;
    logic [MW-1:0]       pm_reg   [NS];
    logic [MW-1:0]       pm_next  [NS];
    logic [NS-1:0]       dec_next;
    logic [NS-1:0]       surv_mem [LENOUT];
    logic [NS-1:0]       row_reg;
    logic [SW-1:0]       trace_state_reg;
    logic [LENOUT-2:0]   dec_reg;
    logic [MW-1:0]       metric_sel_reg;
    logic                done_reg;
    logic [LENOUT-1:0]   codeout_reg;
    logic [MW-1:0]       metric_reg;
    logic [R-1:0]        sym;
    logic [SW-1:0]       best_idx;
    logic [MW-1:0]       best_pm;
    logic [SW-1:0]       sel_state;
    logic                trace_bit;

    // Path metric plus Hamming branch metric, clamped at PM_MAX. The sum
    // carries one extra bit, enough for PM_MAX + R with R <= 4.
    function automatic logic [MW-1:0] sat_add_bm(
        input logic [MW-1:0]  pm,
        input logic [R-1:0]   rx,
        input logic [R*K-1:0] g,
        input logic [K-1:0]   taps
    );
        logic [MW:0] sum;
        sum = {1'b0, pm};
        for (int j = 0; j < R; j++) begin
            if ((^(g[j*K +: K] & taps)) != rx[j]) begin
                sum = sum + (MW+1)'(1);
            end
        end
        return (sum > {1'b0, PM_MAX}) ? PM_MAX : sum[MW-1:0];
    endfunction

    // Current symbol: the frame register shifts left by R per stage, so
    // symbol bit j is always at LENIN-1-j.
    always_comb begin
        sym = '0;
        for (int j = 0; j < R; j++) begin
            sym[j] = cin_reg[LENIN-1-j];
        end
    end

    // One ACS unit per next state n. Predecessors are {n[K-3:0], b}; the
    // encoder register seen on that branch is {u, pred} with u = n[K-2].
    for (genvar gi = 0; gi < NS; gi++) begin : g_acs
        localparam logic [SW-1:0] N  = SW'(gi);
        localparam logic [SW-1:0] P0 = {N[SW-2:0], 1'b0};
        localparam logic [SW-1:0] P1 = {N[SW-2:0], 1'b1};
        logic [MW-1:0] cand0, cand1;
        assign cand0 = sat_add_bm(pm_reg[P0], sym, gens_reg, {N[SW-1], P0});
        assign cand1 = sat_add_bm(pm_reg[P1], sym, gens_reg, {N[SW-1], P1});
        // Strict compare so that b=0 wins ties
        assign pm_next[gi]  = (cand1 < cand0) ? cand1 : cand0;
        assign dec_next[gi] = (cand1 < cand0);
    end

    // Minimum-metric state, lowest index wins ties
    always_comb begin
        best_idx = '0;
        best_pm  = pm_reg[0];
        for (int i = 1; i < NS; i++) begin
            if (pm_reg[i] < best_pm) begin
                best_pm  = pm_reg[i];
                best_idx = SW'(i);
            end
        end
        sel_state = term_reg ? '0 : best_idx;
    end

    assign trace_bit = trace_state_reg[SW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACS;
            ACS:     if (cnt_reg == LAST) state_next = SELECT;
            SELECT:  state_next = FETCH;
            FETCH:   state_next = TRACE;
            TRACE:   if (cnt_reg == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg         <= '0;
            cin_reg         <= '0;
            gens_reg        <= '0;
            term_reg        <= 1'b0;
            row_reg         <= '0;
            trace_state_reg <= '0;
            dec_reg         <= '0;
            metric_sel_reg  <= '0;
            done_reg        <= 1'b0;
            codeout_reg     <= '0;
            metric_reg      <= '0;
            for (int i = 0; i < NS; i++) pm_reg[i] <= '0;
            for (int i = 0; i < LENOUT; i++) surv_mem[i] <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cin_reg  <= codein;
                        gens_reg <= gens;
                        term_reg <= term;
                        cnt_reg  <= '0;
                        for (int i = 0; i < NS; i++) begin
                            pm_reg[i] <= (i == 0) ? '0 : PM_MAX;
                        end
                    end
                end
                ACS: begin
                    for (int i = 0; i < NS; i++) pm_reg[i] <= pm_next[i];
                    surv_mem[cnt_reg] <= dec_next;
                    cin_reg <= cin_reg << R;
                    // Counter parks at LAST, which is where traceback starts
                    if (cnt_reg != LAST) cnt_reg <= cnt_reg + TW'(1);
                end
                SELECT: begin
                    trace_state_reg <= sel_state;
                    metric_sel_reg  <= pm_reg[sel_state];
                end
                FETCH: begin
                    // Survivor rows are read through a register; prime it
                    // with the last stage before traceback begins.
                    row_reg <= surv_mem[LAST];
                end
                TRACE: begin
                    trace_state_reg <= {trace_state_reg[SW-2:0], row_reg[trace_state_reg]};
                    dec_reg <= {trace_bit, dec_reg[LENOUT-2:1]};
                    if (cnt_reg != '0) begin
                        row_reg <= surv_mem[cnt_reg - TW'(1)];
                        cnt_reg <= cnt_reg - TW'(1);
                    end else begin
                        done_reg    <= 1'b1;
                        codeout_reg <= {trace_bit, dec_reg};
                        metric_reg  <= metric_sel_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign codeout = codeout_reg;
    assign metric  = metric_reg;

endmodule
